// File: rtl/adc_avg_pkg.sv
// Shared constants, state type and full-scale helper for the ADC sample averager.
package adc_avg_pkg;

  localparam int ADC_W = 16;

  localparam logic [ADC_W-1:0] ADC_FS_POS = 16'h7FFF;
  localparam logic [ADC_W-1:0] ADC_FS_NEG = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The ADS1118 saturates to these codes when the input exceeds the PGA range.
  function automatic logic is_full_scale(input logic [ADC_W-1:0] code);
    return (code == ADC_FS_POS) || (code == ADC_FS_NEG);
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer plus history flop; emits a registered one-cycle pulse
// on each rising edge of an asynchronous level.
module sync_rise (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_pulse
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_hist;
  logic [1:0] r_warm;
  logic       r_pulse;
  logic       w_rise;

  // r_warm[1] marks that r_sync2 holds a real sample rather than its reset value.
  // Until then the history is forced high, so a level already high when reset
  // releases must first be seen low before it can produce a pulse.
  assign w_rise = r_sync2 & ~r_hist & r_warm[1];

  // Synchronize, track history and register the edge pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b1;
      r_warm  <= 2'b00;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_hist  <= r_warm[1] ? r_sync2 : 1'b1;
      r_warm  <= {r_warm[0], 1'b1};
      r_pulse <= w_rise;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/adc_sample_avg.sv
// Windowed average of ADS1118 conversion results over N = 2^LOG2N samples,
// with per-window full-scale flag. Optional min/max tracking is enabled by
// defining ADC_AVG_MINMAX_EN; without it min_out/max_out are tied to zero.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | en low: window cleared, published outputs held
// RUN   | en high: accepting samples, publishing every N samples
module adc_sample_avg
  import adc_avg_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic             CLK_50M,
  input  logic             rst,
  input  logic             en,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_done,
  output logic [ADC_W-1:0] avg_out,
  output logic             avg_vld,
  output logic [ADC_W-1:0] min_out,
  output logic [ADC_W-1:0] max_out,
  output logic             ovr
);

  localparam int ACC_W = ADC_W + LOG2N;
  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run;

  logic                    w_strobe;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_first;
  logic signed [ADC_W-1:0] w_sample;
  logic signed [ACC_W-1:0] w_sample_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic        [ADC_W-1:0] w_avg;
  logic                    w_ovr_nxt;

  logic signed [ACC_W-1:0] r_acc;
  logic        [LOG2N-1:0] r_cnt;
  logic                    r_ovr_acc;
  logic        [ADC_W-1:0] r_avg;
  logic                    r_avg_vld;
  logic                    r_ovr;

  sync_rise u_sync_rise (
    .i_clk   (CLK_50M),
    .i_rst   (rst),
    .i_async (adc_done),
    .o_pulse (w_strobe)
  );

  // State register.
  always_ff @(posedge CLK_50M) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state follows en; w_run gates sample acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      IDLE: if (en) w_state_nxt = RUN;
      RUN: begin
        w_run = 1'b1;
        if (!en) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A strobe arriving in the cycle en drops is dropped with the partial window.
  assign w_accept     = w_strobe & en & w_run;
  assign w_last       = (r_cnt == CNT_LAST);
  assign w_first      = (r_cnt == '0);
  assign w_sample     = $signed(adc_data);
  assign w_sample_ext = {{LOG2N{w_sample[ADC_W-1]}}, w_sample};
  assign w_sum        = r_acc + w_sample_ext;
  // Arithmetic shift floors; the mean of 16-bit samples always fits 16 bits.
  assign w_avg        = ADC_W'(w_sum >>> LOG2N);
  assign w_ovr_nxt    = r_ovr_acc | is_full_scale(adc_data);

  // Accumulate the window and publish on its last sample.
  always_ff @(posedge CLK_50M) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovr_acc <= 1'b0;
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
      r_ovr     <= 1'b0;
    end else if (!w_run) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovr_acc <= 1'b0;
      r_avg_vld <= 1'b0;
    end else begin
      r_avg_vld <= 1'b0;
      if (w_accept) begin
        if (w_last) begin
          r_acc     <= '0;
          r_cnt     <= '0;
          r_ovr_acc <= 1'b0;
          r_avg     <= w_avg;
          r_ovr     <= w_ovr_nxt;
          r_avg_vld <= 1'b1;
        end else begin
          r_acc     <= w_sum;
          r_cnt     <= r_cnt + CNT_ONE;
          r_ovr_acc <= w_ovr_nxt;
        end
      end
    end
  end

  assign avg_out = r_avg;
  assign avg_vld = r_avg_vld;
  assign ovr     = r_ovr;

`ifdef ADC_AVG_MINMAX_EN
  logic signed [ADC_W-1:0] r_min;
  logic signed [ADC_W-1:0] r_max;
  logic signed [ADC_W-1:0] r_min_out;
  logic signed [ADC_W-1:0] r_max_out;
  logic signed [ADC_W-1:0] w_min_nxt;
  logic signed [ADC_W-1:0] w_max_nxt;

  // The first sample of a window seeds both extremes.
  always_comb begin
    w_min_nxt = r_min;
    w_max_nxt = r_max;
    if (w_first || (w_sample < r_min)) w_min_nxt = w_sample;
    if (w_first || (w_sample > r_max)) w_max_nxt = w_sample;
  end

  // Track running extremes and publish them alongside the average.
  always_ff @(posedge CLK_50M) begin
    if (rst) begin
      r_min     <= '0;
      r_max     <= '0;
      r_min_out <= '0;
      r_max_out <= '0;
    end else if (!w_run) begin
      r_min <= '0;
      r_max <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_min     <= '0;
        r_max     <= '0;
        r_min_out <= w_min_nxt;
        r_max_out <= w_max_nxt;
      end else begin
        r_min <= w_min_nxt;
        r_max <= w_max_nxt;
      end
    end
  end

  assign min_out = r_min_out;
  assign max_out = r_max_out;
`else
  assign min_out = '0;
  assign max_out = '0;
`endif

endmodule

// File: tb/tb_adc_sample_avg.sv
// Bench for adc_sample_avg: directed windows plus randomized windows checked
// against an arithmetic window model; a LOG2N=6 instance covers the wide window.
module tb_adc_sample_avg;

  typedef struct packed {
    logic [15:0] avg;
    logic [15:0] mn;
    logic [15:0] mx;
    logic        ov;
  } res_t;

`ifdef ADC_AVG_MINMAX_EN
  localparam logic [15:0] MM_MASK = 16'hFFFF;
`else
  localparam logic [15:0] MM_MASK = 16'h0000;
`endif

  logic        CLK_50M = 1'b0;
  logic        rst;
  logic        en;
  logic        en6;
  logic        adc_done;
  logic [15:0] adc_data;

  logic [15:0] avg_out, min_out, max_out;
  logic        avg_vld, ovr;
  logic [15:0] avg6, min6, max6;
  logic        vld6, ovr6;

  int n_tests = 0;
  int n_fail  = 0;

  res_t obs_q[$];
  res_t obs6_q[$];

  always #10 CLK_50M = ~CLK_50M;

  adc_sample_avg #(.LOG2N(2)) dut (
    .CLK_50M  (CLK_50M),
    .rst      (rst),
    .en       (en),
    .adc_data (adc_data),
    .adc_done (adc_done),
    .avg_out  (avg_out),
    .avg_vld  (avg_vld),
    .min_out  (min_out),
    .max_out  (max_out),
    .ovr      (ovr)
  );

  adc_sample_avg #(.LOG2N(6)) dut6 (
    .CLK_50M  (CLK_50M),
    .rst      (rst),
    .en       (en6),
    .adc_data (adc_data),
    .adc_done (adc_done),
    .avg_out  (avg6),
    .avg_vld  (vld6),
    .min_out  (min6),
    .max_out  (max6),
    .ovr      (ovr6)
  );

  // Record every published window, one entry per cycle avg_vld is high.
  always @(negedge CLK_50M) begin
    if (avg_vld) obs_q.push_back('{avg: avg_out, mn: min_out, mx: max_out, ov: ovr});
    if (vld6)    obs6_q.push_back('{avg: avg6, mn: min6, mx: max6, ov: ovr6});
  end

  // Expected publication for a complete window: floor of the mean, extremes, full-scale flag.
  function automatic res_t model(input int s[$], input int log2n);
    res_t r;
    int   sum = 0;
    int   n   = 1 << log2n;
    int   q;
    int   mn  = s[0];
    int   mx  = s[0];
    logic ov  = 1'b0;
    foreach (s[i]) begin
      sum += s[i];
      if (s[i] < mn) mn = s[i];
      if (s[i] > mx) mx = s[i];
      if (s[i] == 32767 || s[i] == -32768) ov = 1'b1;
    end
    q = sum / n;
    if (sum < 0 && (sum % n) != 0) q = q - 1;
    r.avg = q[15:0];
    r.mn  = mn[15:0] & MM_MASK;
    r.mx  = mx[15:0] & MM_MASK;
    r.ov  = ov;
    return r;
  endfunction

  task automatic send(input logic [15:0] d);
    @(negedge CLK_50M); adc_data = d;
    @(negedge CLK_50M); adc_done = 1'b1;
    repeat (3) @(negedge CLK_50M); adc_done = 1'b0;
    repeat (2) @(negedge CLK_50M);
  endtask

  task automatic send_fast(input logic [15:0] d);
    @(negedge CLK_50M); adc_data = d;
    @(negedge CLK_50M); adc_done = 1'b1;
    @(negedge CLK_50M); adc_done = 1'b0;
    repeat (2) @(negedge CLK_50M);
  endtask

  task automatic restart();
    @(negedge CLK_50M); en = 1'b0;
    repeat (2) @(negedge CLK_50M); en = 1'b1;
    repeat (2) @(negedge CLK_50M);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en6 = 1'b0; adc_done = 1'b0; adc_data = 16'h1234;
    repeat (3) @(negedge CLK_50M);
    n_tests++; if (avg_out !== 16'h0) begin n_fail++; $display("FAIL reset_avg got %h want 0000", avg_out); end
    n_tests++; if (avg_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", avg_vld); end
    n_tests++; if (min_out !== 16'h0 || max_out !== 16'h0) begin n_fail++; $display("FAIL reset_minmax got %h/%h want 0000/0000", min_out, max_out); end
    n_tests++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b want 0", ovr); end
    rst = 1'b0;
    repeat (2) @(negedge CLK_50M);
  endtask

  task automatic test_basic();
    res_t r;
    restart();
    obs_q.delete();
    send(16'd100); send(16'd200); send(16'd300); send(16'd400);
    repeat (4) @(negedge CLK_50M);
    r = (obs_q.size() > 0) ? obs_q[0] : '0;
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL basic_count got %0d want 1", obs_q.size()); end
    n_tests++; if (r.avg !== 16'd250) begin n_fail++; $display("FAIL basic_avg got %0d want 250", r.avg); end
    n_tests++; if (r.mn !== (16'd100 & MM_MASK) || r.mx !== (16'd400 & MM_MASK)) begin
      n_fail++; $display("FAIL basic_minmax got %0d/%0d want %0d/%0d", r.mn, r.mx, 16'd100 & MM_MASK, 16'd400 & MM_MASK);
    end
    n_tests++; if (r.ov !== 1'b0) begin n_fail++; $display("FAIL basic_ovr got %b want 0", r.ov); end
  endtask

  task automatic test_floor();
    res_t r;
    obs_q.delete();
    send(16'hFFFF); send(16'hFFFF); send(16'hFFFF); send(16'hFFFE);
    repeat (4) @(negedge CLK_50M);
    r = (obs_q.size() > 0) ? obs_q[0] : '0;
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL floor_count got %0d want 1", obs_q.size()); end
    n_tests++; if (r.avg !== 16'hFFFE) begin n_fail++; $display("FAIL floor_avg got %h want fffe", r.avg); end
    n_tests++; if (r.mn !== (16'hFFFE & MM_MASK) || r.mx !== (16'hFFFF & MM_MASK)) begin
      n_fail++; $display("FAIL floor_minmax got %h/%h want %h/%h", r.mn, r.mx, 16'hFFFE & MM_MASK, 16'hFFFF & MM_MASK);
    end
  endtask

  task automatic test_ovr();
    res_t r0, r1;
    obs_q.delete();
    send(16'h7FFF); send(16'h0); send(16'h0); send(16'h0);
    send(16'h0);    send(16'h0); send(16'h0); send(16'h0);
    repeat (4) @(negedge CLK_50M);
    r0 = (obs_q.size() > 0) ? obs_q[0] : '0;
    r1 = (obs_q.size() > 1) ? obs_q[1] : '1;
    n_tests++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL ovr_count got %0d want 2", obs_q.size()); end
    n_tests++; if (r0.ov !== 1'b1 || r0.avg !== 16'h1FFF) begin n_fail++; $display("FAIL ovr_first got ovr=%b avg=%h want ovr=1 avg=1fff", r0.ov, r0.avg); end
    n_tests++; if (r1.ov !== 1'b0 || r1.avg !== 16'h0) begin n_fail++; $display("FAIL ovr_second got ovr=%b avg=%h want ovr=0 avg=0000", r1.ov, r1.avg); end
  endtask

  task automatic test_en_drop();
    res_t r;
    obs_q.delete();
    send(16'd1000); send(16'd1000); send(16'd1000);
    @(negedge CLK_50M); en = 1'b0;
    repeat (3) @(negedge CLK_50M);
    n_tests++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL endrop_partial got %0d pulses want 0", obs_q.size()); end
    en = 1'b1;
    repeat (2) @(negedge CLK_50M);
    send(16'd8); send(16'd8); send(16'd8); send(16'd8);
    repeat (4) @(negedge CLK_50M);
    r = (obs_q.size() > 0) ? obs_q[0] : '0;
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL endrop_count got %0d want 1", obs_q.size()); end
    n_tests++; if (r.avg !== 16'd8) begin n_fail++; $display("FAIL endrop_avg got %0d want 8", r.avg); end
  endtask

  task automatic test_latency();
    @(negedge CLK_50M); rst = 1'b1; en = 1'b1; adc_done = 1'b1; adc_data = 16'd20;
    repeat (3) @(negedge CLK_50M); rst = 1'b0;
    repeat (8) @(negedge CLK_50M); adc_done = 1'b0;
    repeat (4) @(negedge CLK_50M);
    obs_q.delete();
    send(16'd20); send(16'd20); send(16'd20);
    repeat (2) @(negedge CLK_50M);
    n_tests++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL lat_no_spurious got %0d pulses want 0", obs_q.size()); end
    @(negedge CLK_50M); adc_data = 16'd40;
    @(negedge CLK_50M); adc_done = 1'b1;
    @(posedge CLK_50M);
    @(posedge CLK_50M);
    @(posedge CLK_50M); #1;
    n_tests++; if (avg_vld !== 1'b0) begin n_fail++; $display("FAIL lat_early got %b want 0 at k+2", avg_vld); end
    @(posedge CLK_50M); #1;
    n_tests++; if (avg_vld !== 1'b1 || avg_out !== 16'd25) begin n_fail++; $display("FAIL lat_k3 got vld=%b avg=%0d want vld=1 avg=25", avg_vld, avg_out); end
    @(posedge CLK_50M); #1;
    n_tests++; if (avg_vld !== 1'b0) begin n_fail++; $display("FAIL lat_width got %b want 0 at k+4", avg_vld); end
    @(negedge CLK_50M); adc_done = 1'b0;
    repeat (3) @(negedge CLK_50M);
  endtask

  task automatic test_random();
    int   smp[$];
    res_t exp_q[$];
    logic [15:0] d;
    res_t r;
    restart();
    obs_q.delete();
    for (int w = 0; w < 6; w++) begin
      smp.delete();
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        else                           d = 16'($urandom);
        smp.push_back(int'($signed(d)));
        send_fast(d);
      end
      exp_q.push_back(model(smp, 2));
    end
    repeat (4) @(negedge CLK_50M);
    n_tests++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      r = (i < obs_q.size()) ? obs_q[i] : ~exp_q[i];
      n_tests++;
      if (r !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_win%0d got avg=%h min=%h max=%h ovr=%b want avg=%h min=%h max=%h ovr=%b",
                 i, r.avg, r.mn, r.mx, r.ov, exp_q[i].avg, exp_q[i].mn, exp_q[i].mx, exp_q[i].ov);
      end
    end
  endtask

  task automatic test_log2n6();
    res_t r0, r1;
    @(negedge CLK_50M); en = 1'b0; en6 = 1'b1;
    repeat (3) @(negedge CLK_50M);
    obs6_q.delete();
    for (int i = 0; i < 64; i++) send_fast(16'h7FFF);
    for (int i = 0; i < 64; i++) send_fast(16'h8000);
    repeat (4) @(negedge CLK_50M);
    r0 = (obs6_q.size() > 0) ? obs6_q[0] : '0;
    r1 = (obs6_q.size() > 1) ? obs6_q[1] : '0;
    n_tests++; if (obs6_q.size() !== 2) begin n_fail++; $display("FAIL wide_count got %0d want 2", obs6_q.size()); end
    n_tests++; if (r0.avg !== 16'h7FFF || r0.ov !== 1'b1) begin n_fail++; $display("FAIL wide_pos got avg=%h ovr=%b want avg=7fff ovr=1", r0.avg, r0.ov); end
    n_tests++; if (r1.avg !== 16'h8000 || r1.ov !== 1'b1) begin n_fail++; $display("FAIL wide_neg got avg=%h ovr=%b want avg=8000 ovr=1", r1.avg, r1.ov); end
    n_tests++; if (r1.mn !== (16'h8000 & MM_MASK) || r1.mx !== (16'h8000 & MM_MASK)) begin
      n_fail++; $display("FAIL wide_minmax got %h/%h want %h/%h", r1.mn, r1.mx, 16'h8000 & MM_MASK, 16'h8000 & MM_MASK);
    end
    en6 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_floor();
    test_ovr();
    test_en_drop();
    test_latency();
    test_random();
    test_log2n6();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sample_avg.md
ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

Interface
REQ-001 SHALL have parameter LOG2N, default 4, meaning window length N = 2^LOG2N samples (legal 1..6).
REQ-002 SHALL have port CLK_50M  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port en  input  1  averaging enable; low clears the window and holds outputs.
REQ-005 SHALL have port adc_data  input  16  two's-complement ADS1118 conversion result, stable before adc_done rises.
REQ-006 SHALL have port adc_done  input  1  conversion-complete level from the ADS1118 stage, asynchronous to CLK_50M.
REQ-007 SHALL have port avg_out  output  16  signed window average.
REQ-008 SHALL have port avg_vld  output  1  one-cycle pulse, avg_out/min_out/max_out/ovr updated.
REQ-009 SHALL have port min_out, max_out  output  16 each  signed window minimum/maximum (see REQ-024).
REQ-010 SHALL have port ovr  output  1  window contained a full-scale code.

Function
REQ-011 SHALL pass adc_done through a 2-flop synchronizer plus a history flop; new-sample strobe = sync & ~history.
REQ-012 SHALL capture adc_data on the strobe cycle; a strobe while en=0 SHALL be ignored.
REQ-013 SHALL implement states IDLE and RUN: IDLE->RUN when en=1; RUN->IDLE when en=0; rst forces IDLE.
REQ-014 In IDLE: accumulator, sample counter, running min/max, ovr-accumulate SHALL be cleared; outputs hold last values.
REQ-015 In RUN, per strobe: acc += sign-extended sample; cnt += 1; accumulator width 16+LOG2N signed, never overflows.
REQ-016 On the strobe where cnt = N-1: avg_out <= (acc+sample) >>> LOG2N (arithmetic, rounding toward -inf), avg_vld=1 next cycle, acc/cnt/min/max/ovr-accumulate reloaded to empty window.
REQ-017 Latency: adc_done rising sampled at CLK_50M edge k -> avg_vld high in cycle k+3 (for completing sample), exactly one cycle.
REQ-018 Sample 0x7FFF or 0x8000 SHALL set the window's ovr-accumulate; ovr output = that value at window completion.
REQ-019 en falling mid-window SHALL discard the partial window, no avg_vld.
REQ-020 Strobes closer than 1 cycle cannot occur (edge detect); strobe coinciding with window completion starts next window empty (no sample loss, none double counted).

Reset
REQ-021 On rst: avg_out=0, min_out=0, max_out=0, ovr=0, avg_vld=0, state IDLE, synchronizer flops=0, acc=0, cnt=0.
REQ-022 adc_done already high when rst releases SHALL NOT generate a strobe (history flop resets alongside, first edge needs a low).

Configuration
REQ-023 Macro ADC_AVG_MINMAX_EN SHALL control min/max tracking.
REQ-024 Defined: running min/max per window, initialized from first sample, published with avg_vld. Undefined: min/max logic absent, min_out=max_out=0 constant.

Structure
REQ-025 Package adc_avg_pkg SHALL hold ADC_W=16, ADC_FS_POS=16'h7FFF, ADC_FS_NEG=16'h8000, state typedef {IDLE, RUN}.
REQ-026 Synchronizer + edge detector SHALL be sub-module sync_rise (in: async level, out: one-cycle pulse).

Verification
REQ-027 LOG2N=2, en=1, samples 100,200,300,400 -> one avg_vld, avg_out=250, min=100, max=400, ovr=0.
REQ-028 LOG2N=2, samples -1,-1,-1,-2 -> avg_out=-2 (0xFFFE), floor rounding confirmed.
REQ-029 LOG2N=2, samples 0x7FFF,0,0,0 -> ovr=1 that window; next window of zeros -> ovr=0, avg_out=0.
REQ-030 en dropped after 3 samples, raised, 4 samples of 8 -> single avg_vld, avg_out=8.
REQ-031 adc_done held high across rst release -> no strobe until adc_done low then high; avg_vld exactly 3 cycles after that rise on 4th sample.
REQ-032 LOG2N=6, 64 samples of 0x7FFF -> avg_out=0x7FFF, no accumulator overflow; repeat 0x8000 -> avg_out=0x8000.
